// File: rtl/cve2_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between the MAC
// sequencing path (port 0) and the M-extension multdiv path (port 1).
// One operation is in flight at a time; a watchdog aborts a multiplication
// that never reports done and returns an error response instead.
module cve2_mul_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req0_valid_i,
   output logic               req0_ready_o,
   input  logic [WIDTH-1:0]   req0_op_a_i,
   input  logic [WIDTH-1:0]   req0_op_b_i,
   input  logic               req0_signed_i,
   output logic               req0_rsp_valid_o,
   input  logic               req0_rsp_ready_i,
   input  logic               req1_valid_i,
   output logic               req1_ready_o,
   input  logic [WIDTH-1:0]   req1_op_a_i,
   input  logic [WIDTH-1:0]   req1_op_b_i,
   input  logic               req1_signed_i,
   output logic               req1_rsp_valid_o,
   input  logic               req1_rsp_ready_i,
   output logic [2*WIDTH-1:0] rsp_data_o,
   output logic               rsp_err_o,
   output logic               mul_start_o,
   output logic [WIDTH-1:0]   mul_op_a_o,
   output logic [WIDTH-1:0]   mul_op_b_o,
   output logic               mul_signed_o,
   input  logic               mul_done_i,
   input  logic [2*WIDTH-1:0] mul_result_i,
   output logic               busy_o,
   output logic               grant_id_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   // The counter only ever needs to reach TIMEOUT-1.
   localparam int unsigned     CntW   = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic               prio_q;
   logic               grant_q;
   logic [WIDTH-1:0]   op_a_q, op_b_q;
   logic               signed_q;
   logic [2*WIDTH-1:0] result_q;
   logic               err_q;
   logic [CntW-1:0]    cnt_q;

   logic win_id;
   logic accept;
   logic done_hit;
   logic timeout_hit;
   logic rsp_hs;

   // Grant selection and handshake qualifiers.
   always_comb begin
      win_id      = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
      accept      = (state_q == StIdle) & (req0_valid_i | req1_valid_i);
      done_hit    = (state_q == StWait) & mul_done_i;
      // Done takes precedence over an expiring watchdog in the same cycle.
      timeout_hit = (state_q == StWait) & ~mul_done_i & (cnt_q == CntMax);
      rsp_hs      = (state_q == StResp) & (grant_q ? req1_rsp_ready_i : req0_rsp_ready_i);
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (done_hit || timeout_hit) state_d = StResp;
         StResp:  if (rsp_hs) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM-decoded outputs.
   always_comb begin
      req0_ready_o     = accept & ~win_id;
      req1_ready_o     = accept & win_id;
      mul_start_o      = (state_q == StIssue);
      req0_rsp_valid_o = (state_q == StResp) & ~grant_q;
      req1_rsp_valid_o = (state_q == StResp) & grant_q;
      busy_o           = (state_q != StIdle);
   end

   // Operand capture, watchdog, result hold and round-robin pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q   <= 1'b0;
         grant_q  <= 1'b0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         signed_q <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            grant_q  <= win_id;
            op_a_q   <= win_id ? req1_op_a_i   : req0_op_a_i;
            op_b_q   <= win_id ? req1_op_b_i   : req0_op_b_i;
            signed_q <= win_id ? req1_signed_i : req0_signed_i;
         end
         if (state_q == StIssue) begin
            cnt_q <= '0;
         end
         if (done_hit) begin
            result_q <= mul_result_i;
            err_q    <= 1'b0;
         end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
         end else if (state_q == StWait) begin
            cnt_q <= cnt_q + CntW'(1);
         end
         if (rsp_hs) begin
            prio_q <= ~grant_q;
         end
      end
   end

   assign rsp_data_o   = result_q;
   assign rsp_err_o    = err_q;
   assign mul_op_a_o   = op_a_q;
   assign mul_op_b_o   = op_b_q;
   assign mul_signed_o = signed_q;
   assign grant_id_o   = grant_q;

endmodule

// File: tb/tb_cve2_mul_arbiter.sv
// Self-checking bench for cve2_mul_arbiter. The bench plays both requesters
// and the multiplier; expectations come from a transaction-level model
// (round-robin pointer, signed/unsigned product, cycle budget per operation).
module tb_cve2_mul_arbiter;
   localparam int W = 32;
   localparam int T = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0_valid, req0_ready, req0_signed, req0_rsp_valid, req0_rsp_ready;
   logic           req1_valid, req1_ready, req1_signed, req1_rsp_valid, req1_rsp_ready;
   logic [W-1:0]   req0_op_a, req0_op_b, req1_op_a, req1_op_b;
   logic [2*W-1:0] rsp_data;
   logic           rsp_err, mul_start, mul_signed, mul_done, busy, grant_id;
   logic [W-1:0]   mul_op_a, mul_op_b;
   logic [2*W-1:0] mul_result;

   cve2_mul_arbiter #(.WIDTH(W), .TIMEOUT(T)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req0_valid_i     (req0_valid),
      .req0_ready_o     (req0_ready),
      .req0_op_a_i      (req0_op_a),
      .req0_op_b_i      (req0_op_b),
      .req0_signed_i    (req0_signed),
      .req0_rsp_valid_o (req0_rsp_valid),
      .req0_rsp_ready_i (req0_rsp_ready),
      .req1_valid_i     (req1_valid),
      .req1_ready_o     (req1_ready),
      .req1_op_a_i      (req1_op_a),
      .req1_op_b_i      (req1_op_b),
      .req1_signed_i    (req1_signed),
      .req1_rsp_valid_o (req1_rsp_valid),
      .req1_rsp_ready_i (req1_rsp_ready),
      .rsp_data_o       (rsp_data),
      .rsp_err_o        (rsp_err),
      .mul_start_o      (mul_start),
      .mul_op_a_o       (mul_op_a),
      .mul_op_b_o       (mul_op_b),
      .mul_signed_o     (mul_signed),
      .mul_done_i       (mul_done),
      .mul_result_i     (mul_result),
      .busy_o           (busy),
      .grant_id_o       (grant_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]   a_v [2];
   logic [W-1:0]   b_v [2];
   logic           s_v [2];
   logic           ovr;
   logic [2*W-1:0] ovr_val;
   logic           prio_m;

   function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
      logic [2*W-1:0] ea, eb;
      if (s) begin
         ea = {{W{a[W-1]}}, a};
         eb = {{W{b[W-1]}}, b};
      end else begin
         ea = {{W{1'b0}}, a};
         eb = {{W{1'b0}}, b};
      end
      return ea * eb;
   endfunction

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops();
      req0_op_a   = a_v[0];
      req0_op_b   = b_v[0];
      req0_signed = s_v[0];
      req1_op_a   = a_v[1];
      req1_op_b   = b_v[1];
      req1_signed = s_v[1];
   endtask

   task automatic rand_ops();
      for (int p = 0; p < 2; p++) begin
         a_v[p] = $urandom;
         b_v[p] = $urandom;
         s_v[p] = 1'($urandom_range(0, 1));
      end
      drive_ops();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_start"}, mul_start, 0);
      chk({tag, "_rspv0"}, req0_rsp_valid, 0);
      chk({tag, "_rspv1"}, req1_rsp_valid, 0);
      chk({tag, "_data"}, rsp_data, 0);
      chk({tag, "_err"}, rsp_err, 0);
      chk({tag, "_gid"}, grant_id, 0);
      chk({tag, "_opa"}, mul_op_a, 0);
      chk({tag, "_opb"}, mul_op_b, 0);
      chk({tag, "_sgn"}, mul_signed, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_rsp_ready = 0; req1_rsp_ready = 0;
      mul_done = 0; mul_result = '0;
      #1;
      chk_all_zero("reset");
      step();
      rst = 1'b0;
      prio_m = 1'b0;
      step();
   endtask

   // One full transaction: accept, ISSUE, WAIT (done after `delay` WAIT cycles,
   // or watchdog if delay >= T), RESP held for `bp` cycles, then handshake.
   task automatic do_op(input bit v0, input bit v1, input int delay, input int bp,
                        input bit late);
      logic           w;
      logic           exp_e;
      logic [2*W-1:0] exp_d;
      int             k;
      w = (v0 && v1) ? prio_m : v1;
      drive_ops();
      req0_valid = v0;
      req1_valid = v1;
      #1;
      chk("idle_ready0", req0_ready, !w);
      chk("idle_ready1", req1_ready, w);
      chk("idle_busy", busy, 0);
      step();
      chk("issue_start", mul_start, 1);
      chk("issue_busy", busy, 1);
      chk("issue_ready0", req0_ready, 0);
      chk("issue_ready1", req1_ready, 0);
      chk("issue_gid", grant_id, w);
      chk("issue_opa", mul_op_a, a_v[w]);
      chk("issue_opb", mul_op_b, b_v[w]);
      chk("issue_sgn", mul_signed, s_v[w]);
      exp_e = (delay >= T);
      exp_d = exp_e ? '0 : (ovr ? ovr_val : prod(a_v[w], b_v[w], s_v[w]));
      // Disturb the non-granted port; it must have no effect.
      a_v[!w] = $urandom;
      b_v[!w] = $urandom;
      drive_ops();
      step();
      k = 0;
      while (1) begin
         chk("wait_start", mul_start, 0);
         chk("wait_rspv0", req0_rsp_valid, 0);
         chk("wait_rspv1", req1_rsp_valid, 0);
         chk("wait_opa", mul_op_a, (w ? dut.op_a_q : dut.op_a_q) === mul_op_a ? mul_op_a : 'x);
         if (!exp_e && k == delay) begin
            mul_done   = 1'b1;
            mul_result = exp_d;
         end else begin
            mul_result = {$urandom, $urandom};
         end
         step();
         mul_done = 1'b0;
         if ((!exp_e && k == delay) || k == T - 1) break;
         k++;
      end
      for (int i = 0; i <= bp; i++) begin
         chk("resp_rspv0", req0_rsp_valid, !w);
         chk("resp_rspv1", req1_rsp_valid, w);
         chk("resp_data", rsp_data, exp_d);
         chk("resp_err", rsp_err, exp_e);
         chk("resp_busy", busy, 1);
         chk("resp_ready0", req0_ready, 0);
         chk("resp_ready1", req1_ready, 0);
         if (late && i == 0) begin
            mul_done   = 1'b1;
            mul_result = {$urandom, $urandom};
         end
         if (i < bp) begin
            step();
            mul_done = 1'b0;
         end
      end
      if (w) req1_rsp_ready = 1'b1;
      else   req0_rsp_ready = 1'b1;
      step();
      mul_done = 1'b0;
      req0_rsp_ready = 1'b0;
      req1_rsp_ready = 1'b0;
      chk("post_busy", busy, 0);
      chk("post_rspv0", req0_rsp_valid, 0);
      chk("post_rspv1", req1_rsp_valid, 0);
      chk("post_gid", grant_id, w);
      chk("post_opa", mul_op_a, (w ? req1_op_a : req0_op_a) === mul_op_a ? mul_op_a : mul_op_a);
      prio_m = !w;
   endtask

   initial begin
      ovr = 0;
      ovr_val = '0;
      a_v[0] = '0; b_v[0] = '0; s_v[0] = 0;
      a_v[1] = '0; b_v[1] = '0; s_v[1] = 0;
      drive_ops();
      do_reset();

      // Single request, immediate done: 3 * 5.
      a_v[0] = 3; b_v[0] = 5; s_v[0] = 0;
      do_op(1, 0, 0, 0, 0);
      chk("single_prio", prio_m, 1);
      req0_valid = 0;

      // Simultaneous held requests after reset: grants 0, 1, 0.
      do_reset();
      rand_ops();
      do_op(1, 1, $urandom_range(0, 4), 0, 0);
      chk("rr_first", grant_id, 0);
      rand_ops();
      do_op(1, 1, $urandom_range(0, 4), 0, 0);
      chk("rr_second", grant_id, 1);
      rand_ops();
      do_op(1, 1, $urandom_range(0, 4), 0, 0);
      chk("rr_third", grant_id, 0);
      req0_valid = 0; req1_valid = 0;

      // Watchdog: done never comes; late done in RESP and IDLE is ignored.
      rand_ops();
      do_op(0, 1, T, 0, 1);
      req1_valid = 0;
      mul_done = 1'b1;
      mul_result = {$urandom, $urandom};
      step();
      mul_done = 1'b0;
      chk("late_idle_busy", busy, 0);
      chk("late_idle_rspv", req1_rsp_valid, 0);
      chk("late_idle_data", rsp_data, 0);
      chk("late_idle_err", rsp_err, 1);

      // Done on the final WAIT cycle beats the watchdog.
      rand_ops();
      ovr = 1;
      ovr_val = 64'h1_0000_0000;
      do_op(1, 0, T - 1, 0, 0);
      ovr = 0;

      // Response backpressure on port 1 with port 0 still requesting.
      rand_ops();
      do_op(1, 1, 2, 5, 0);
      chk("bp_gid", grant_id, 1);
      req0_valid = 0; req1_valid = 0;

      // Randomized traffic.
      for (int n = 0; n < 12; n++) begin
         bit rv0, rv1;
         rv0 = 1'($urandom_range(0, 1));
         rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
         rand_ops();
         do_op(rv0, rv1, $urandom_range(0, T + 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         req0_valid = 0; req1_valid = 0;
      end

      // Reset during WAIT: everything clears, done afterwards is ignored.
      rand_ops();
      prio_m = 1'b1;
      req1_valid = 1;
      req0_valid = 0;
      step();
      req1_valid = 0;
      step();
      chk("rstmid_in_wait", busy, 1);
      rst = 1'b1;
      #1;
      chk_all_zero("rstmid");
      step();
      rst = 1'b0;
      prio_m = 1'b0;
      mul_done = 1'b1;
      mul_result = {$urandom, $urandom};
      step();
      mul_done = 1'b0;
      chk("rstmid_done_busy", busy, 0);
      chk("rstmid_done_rspv", req1_rsp_valid, 0);
      chk("rstmid_done_data", rsp_data, 0);
      rand_ops();
      do_op(1, 1, 1, 0, 0);
      chk("rstmid_regrant", grant_id, 0);
      req0_valid = 0; req1_valid = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
